// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared types and constants for the RV32 fetch front end.
//               fetch_state_t  - fetch controller state encoding
//               INST_ALIGN_MASK - clears the byte-offset bits of a PC
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    localparam logic [31:0] INST_ALIGN_MASK = 32'hFFFF_FFFC;

    // Buffer entry layout: {fault, pc[31:0], data[31:0]}
    localparam int FETCH_ENTRY_W = 65;

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/rv32_mod_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_fetch_fifo
// Description : Instruction buffer between memory responses and the decoder.
//               Entries are {fault, pc, data}. The head entry is visible on
//               rd_data whenever empty is low. flush empties the buffer at the
//               end of the cycle and overrides any write or read in it.
// Ports       : clk, rst_n          - clock, async active-low reset
//               flush              - synchronous empty request
//               wr_en, wr_data     - push one entry (caller guarantees space)
//               rd_en              - pop the head entry
//               rd_data, empty     - head entry, buffer empty flag
//               count              - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_fetch_fifo
    import rv32_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          wr_en,
    input  logic [FETCH_ENTRY_W-1:0]      wr_data,
    input  logic                          rd_en,
    output logic [FETCH_ENTRY_W-1:0]      rd_data,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);

    logic [FETCH_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW:0]            r_wr_ptr;
    logic [c_AW:0]            r_rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only observed when not empty.
    always_ff @(posedge clk) begin
        if (wr_en && !flush) r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end

    assign rd_data = r_mem[r_rd_ptr[c_AW-1:0]];
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign count   = r_wr_ptr - r_rd_ptr;

endmodule : rv32_mod_fetch_fifo
`default_nettype wire

// File: rtl/rv32_mod_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : rv32_mod_fetch_controller
// Description : RV32 instruction fetch controller. Issues sequential word
//               fetches under a credit limit, buffers in-order responses with
//               their PC, handles redirects (flush + stale-response drain) and
//               bus errors (FAULT until redirected).
// Ports       : clk, rst_n                       - clock, async active-low reset
//               redirect_valid, redirect_pc      - new fetch target
//               mem_req_valid/ready/addr         - fetch request channel
//               mem_rsp_valid/data/error         - in-order response channel
//               inst_valid/ready/data/pc/fault   - decoder channel
//               busy                             - not idle in FETCH
//               stall_cycles                     - only with RV32_FETCH_PERF_CNT_EN
// Options     : `define RV32_FETCH_PERF_CNT_EN adds the stall_cycles counter.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32_mod_fetch_controller
    import rv32_pkg::*;
#(
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_error,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    output logic        busy
`ifdef RV32_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int               c_CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_CW:0]    c_DEPTH_L = (c_CW + 1)'(FIFO_DEPTH);

    fetch_state_t             r_state;
    fetch_state_t             w_state_next;
    logic [31:0]              r_pc;
    logic [c_CW-1:0]          r_outstanding;
    logic [c_CW-1:0]          r_stale;
    logic [c_CW-1:0]          w_outstanding_next;
    logic [c_CW-1:0]          w_stale_next;
    logic [c_CW:0]            w_credit_used;
    logic                     w_req_fire;
    logic                     w_rsp_live;
    logic [31:0]              w_rsp_pc;
    logic                     w_fifo_empty;
    logic [c_CW-1:0]          w_fifo_count;
    logic [FETCH_ENTRY_W-1:0] w_fifo_rd_data;
    logic                     w_inst_pop;

    assign w_req_fire = mem_req_valid & mem_req_ready;

    // A response is stale if a redirect is happening now or older stale
    // responses are still ahead of it (responses are strictly in order).
    assign w_rsp_live = mem_rsp_valid & ~redirect_valid & (r_stale == '0);

    // Non-stale requests are consecutive words ending just below r_pc, so the
    // oldest one sits outstanding*4 below it. With nothing outstanding the
    // response can only belong to the request accepted this very cycle.
    assign w_rsp_pc = r_pc - {{(30 - c_CW){1'b0}}, r_outstanding, 2'b00};

    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count};

    // ------------------------------------------------------------------------
    // Request / stale bookkeeping
    // ------------------------------------------------------------------------
    always_comb begin
        w_outstanding_next = r_outstanding;
        w_stale_next       = r_stale;
        if (redirect_valid) begin
            // Everything still in flight becomes stale, minus a response
            // arriving right now (it is discarded this cycle).
            w_outstanding_next = '0;
            w_stale_next       = r_outstanding + r_stale - c_CW'(mem_rsp_valid);
        end else begin
            if (w_req_fire) w_outstanding_next = w_outstanding_next + c_CW'(1);
            if (w_rsp_live) w_outstanding_next = w_outstanding_next - c_CW'(1);
            if (mem_rsp_valid && (r_stale != '0)) w_stale_next = r_stale - c_CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            r_stale       <= w_stale_next;
            if (redirect_valid)  r_pc <= redirect_pc & INST_ALIGN_MASK;
            else if (w_req_fire) r_pc <= r_pc + 32'd4;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_next;
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = (w_stale_next != '0) ? FLUSH : FETCH;
        end else begin
            case (r_state)
                BOOT:    w_state_next = FETCH;
                FETCH:   if (w_rsp_live && mem_rsp_error) w_state_next = FAULT;
                FLUSH:   if (w_stale_next == '0)          w_state_next = FETCH;
                FAULT:   w_state_next = FAULT;
                default: w_state_next = BOOT;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req_valid = (r_state == FETCH) && !redirect_valid && (w_credit_used < c_DEPTH_L);
        mem_req_addr  = r_pc;
        busy          = (r_state != FETCH) || (r_outstanding != '0) || (r_stale != '0);
        inst_valid    = !w_fifo_empty;
        inst_fault    = inst_valid ? w_fifo_rd_data[64]    : 1'b0;
        inst_pc       = inst_valid ? w_fifo_rd_data[63:32] : 32'd0;
        inst_data     = inst_valid ? w_fifo_rd_data[31:0]  : 32'd0;
    end

    assign w_inst_pop = inst_valid & inst_ready;

    rv32_mod_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .wr_en   (w_rsp_live),
        .wr_data ({mem_rsp_error, w_rsp_pc, mem_rsp_data}),
        .rd_en   (w_inst_pop),
        .rd_data (w_fifo_rd_data),
        .empty   (w_fifo_empty),
        .count   (w_fifo_count)
    );

`ifdef RV32_FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (!inst_valid && ((r_state == FETCH) || (r_state == FLUSH))
                     && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule : rv32_mod_fetch_controller
`default_nettype wire
